// File: rtl/parking_gate_arbiter.sv
// Single-lane barrier arbiter: entry/exit round-robin, capacity check, commit pulses.
// Optional macro GATE_TIMEOUT_EN closes an unused open gate after TIMEOUT_CYCLES.
module parking_gate_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_req,
  input  logic       entry_is_uni,
  input  logic       exit_req,
  input  logic       exit_is_uni,
  input  logic       car_passed,
  input  logic [9:0] uni_vacated_space,
  input  logic [9:0] total_vacated_space,
  output logic       barrier_open,
  output logic       car_entered,
  output logic       is_uni_car_entered,
  output logic       car_exited,
  output logic       is_uni_car_exited,
  output logic       entry_denied,
  output logic       busy
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] ENTRY_OPEN = 2'd1;
  localparam logic [1:0] EXIT_OPEN  = 2'd2;
  localparam logic [1:0] COMMIT     = 2'd3;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0] state;
  logic       uni_q;
  logic       prio_entry;
  logic       entry_ok;
  logic       entry_live;
  logic       grant_exit;
  logic       grant_entry;
  logic       deny;
  logic       start;
  logic       is_open;
  logic       tmo_expired;

  assign entry_ok = (total_vacated_space != '0)
                 && (!entry_is_uni || (uni_vacated_space != '0));

  // A just-denied request sits out one idle cycle before re-evaluation.
  assign entry_live  = entry_req && !entry_denied;
  assign grant_exit  = exit_req && !(entry_live && entry_ok && prio_entry);
  assign grant_entry = entry_live && entry_ok && !grant_exit;
  assign deny        = entry_live && !entry_ok && !exit_req;

  assign start   = (state == IDLE) && (grant_exit || grant_entry);
  assign is_open = (state == ENTRY_OPEN) || (state == EXIT_OPEN);
  assign busy    = (state != IDLE);

`ifdef GATE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo <= '0;
    end else if (start) begin
      tmo <= CW'(TIMEOUT_CYCLES);
    end else if (is_open && (tmo != '0)) begin
      tmo <= tmo - 1'b1;
    end
  end

  // Expires on the edge that takes the counter to zero.
  assign tmo_expired = (tmo == CW'(1));
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      barrier_open       <= 1'b0;
      uni_q              <= 1'b0;
      prio_entry         <= 1'b0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
      entry_denied       <= 1'b0;
    end else begin
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
      entry_denied       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_exit) begin
            state        <= EXIT_OPEN;
            barrier_open <= 1'b1;
            uni_q        <= exit_is_uni;
            prio_entry   <= 1'b1;
          end else if (grant_entry) begin
            state        <= ENTRY_OPEN;
            barrier_open <= 1'b1;
            uni_q        <= entry_is_uni;
            prio_entry   <= 1'b0;
          end else if (deny) begin
            entry_denied <= 1'b1;
          end
        end
        ENTRY_OPEN, EXIT_OPEN: begin
          if (car_passed) begin
            state              <= COMMIT;
            barrier_open       <= 1'b0;
            car_entered        <= (state == ENTRY_OPEN);
            is_uni_car_entered <= (state == ENTRY_OPEN) && uni_q;
            car_exited         <= (state == EXIT_OPEN);
            is_uni_car_exited  <= (state == EXIT_OPEN) && uni_q;
          end else if (tmo_expired) begin
            state        <= IDLE;
            barrier_open <= 1'b0;
          end
        end
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Scoreboard bench for parking_gate_arbiter: transaction-level model,
// random and directed lane traffic, monitor compares commit/deny pulses.
module tb_parking_gate_arbiter;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_req = 1'b0;
  logic       entry_is_uni = 1'b0;
  logic       exit_req = 1'b0;
  logic       exit_is_uni = 1'b0;
  logic       car_passed = 1'b0;
  logic [9:0] uni_vacated_space = '0;
  logic [9:0] total_vacated_space = '0;
  logic       barrier_open;
  logic       car_entered;
  logic       is_uni_car_entered;
  logic       car_exited;
  logic       is_uni_car_exited;
  logic       entry_denied;
  logic       busy;

  parking_gate_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                (clk),
    .reset              (reset),
    .entry_req          (entry_req),
    .entry_is_uni       (entry_is_uni),
    .exit_req           (exit_req),
    .exit_is_uni        (exit_is_uni),
    .car_passed         (car_passed),
    .uni_vacated_space  (uni_vacated_space),
    .total_vacated_space(total_vacated_space),
    .barrier_open       (barrier_open),
    .car_entered        (car_entered),
    .is_uni_car_entered (is_uni_car_entered),
    .car_exited         (car_exited),
    .is_uni_car_exited  (is_uni_car_exited),
    .entry_denied       (entry_denied),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  // kind: 0 entered, 1 exited, 2 denied
  typedef struct {
    int unsigned kind;
    bit          uni;
  } ev_t;

  ev_t exp_q[$];
  int  compared = 0;
  int  mismatched = 0;
  bit  model_prio_entry = 1'b0;

  task automatic check(string name, int unsigned act, int unsigned exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per observed pulse.
  ev_t         mon_e;
  int unsigned mon_k;
  always @(negedge clk) begin
    if (!reset && (car_entered || car_exited || entry_denied)) begin
      check("single_pulse", int'(car_entered) + int'(car_exited)
            + int'(entry_denied), 1);
      mon_k = car_entered ? 0 : (car_exited ? 1 : 2);
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_event: got kind %0d expected none at %0t",
                 mon_k, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", mon_k, mon_e.kind);
        check("event_uni", {is_uni_car_entered, is_uni_car_exited},
              {(mon_e.kind == 0) && mon_e.uni, (mon_e.kind == 1) && mon_e.uni});
      end
    end
  end

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic run_txn(bit ent, bit ext, bit eu, bit xu,
                         int uni, int tot, int delay);
    ev_t plan[$];
    ev_t e;
    bit  pe = ent;
    bit  px = ext;
    bit  ok = (tot != 0) && (!eu || uni != 0);
    int  w;
    while (pe || px) begin
      if (pe && ok && (!px || model_prio_entry)) begin
        e.kind = 0; e.uni = eu; pe = 0; model_prio_entry = 0;
      end else if (px) begin
        e.kind = 1; e.uni = xu; px = 0; model_prio_entry = 1;
      end else begin
        e.kind = 2; e.uni = 0; pe = 0;
      end
      plan.push_back(e);
      exp_q.push_back(e);
    end
    @(negedge clk);
    uni_vacated_space   = 10'(uni);
    total_vacated_space = 10'(tot);
    entry_is_uni = eu;
    exit_is_uni  = xu;
    entry_req    = ent;
    exit_req     = ext;
    foreach (plan[i]) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!(barrier_open || entry_denied) && w < 20);
      check("grant_latency", w, 1);
      if (plan[i].kind == 2) begin
        check("deny_barrier", barrier_open, 0);
        entry_req = 1'b0;
      end else begin
        if (plan[i].kind == 0) entry_req = 1'b0;
        else exit_req = 1'b0;
        repeat (delay) @(negedge clk);
        car_passed = 1'b1;
        @(negedge clk);
        car_passed = 1'b0;
        check("barrier_closed", barrier_open, 0);
        wait_idle();
      end
    end
    entry_req = 1'b0;
    exit_req  = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    #1;
    check("reset_outputs", {barrier_open, busy, car_entered, car_exited,
          entry_denied, is_uni_car_entered, is_uni_car_exited}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Both lanes after reset: exit first, then entry.
    run_txn(1, 1, 0, 1, 3, 3, 2);
    // Uni entry with space, car passes 3 cycles after open.
    run_txn(1, 0, 1, 0, 5, 20, 3);
    // Uni entry with no uni space.
    run_txn(1, 0, 1, 0, 0, 20, 0);
    // Non-uni entry: full lot, then one space.
    run_txn(1, 0, 0, 0, 3, 0, 1);
    run_txn(1, 0, 0, 0, 3, 1, 1);

    // Held denied request is re-evaluated every other cycle.
    repeat (3) exp_q.push_back('{kind: 2, uni: 1'b0});
    @(negedge clk);
    total_vacated_space = '0;
    entry_is_uni = 1'b0;
    entry_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check("deny_cadence", entry_denied, i % 2);
    end
    entry_req = 1'b0;

    // Exit granted, no car passes.
    @(negedge clk);
    exit_is_uni = 1'b1;
    exit_req = 1'b1;
    @(negedge clk);
    check("open_latency", barrier_open, 1);
    exit_req = 1'b0;
    model_prio_entry = 1'b1;
`ifdef GATE_TIMEOUT_EN
    n = 1;
    while (barrier_open && n < 100) begin
      @(negedge clk);
      if (barrier_open) n++;
    end
    check("timeout_open_cycles", n, TO);
    check("timeout_busy", busy, 0);
`else
    n = 0;
    repeat (40) @(negedge clk);
    check("no_timeout_open", barrier_open, 1);
    exp_q.push_back('{kind: 1, uni: 1'b1});
    car_passed = 1'b1;
    @(negedge clk);
    car_passed = 1'b0;
    wait_idle();
`endif

    // Reset in the middle of an entry transaction.
    @(negedge clk);
    total_vacated_space = 10'd4;
    uni_vacated_space = 10'd4;
    entry_is_uni = 1'b0;
    entry_req = 1'b1;
    @(negedge clk);
    check("entry_open", barrier_open, 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset", {barrier_open, busy}, 0);
    entry_req = 1'b0;
    model_prio_entry = 1'b0;
    @(negedge clk);
    car_passed = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    car_passed = 1'b0;
    repeat (3) @(negedge clk);
    run_txn(1, 1, 1, 0, 2, 2, 0);

    // Random traffic.
    for (int t = 0; t < 150; t++) begin
      bit ent = 1'($urandom % 2);
      bit ext = 1'($urandom % 2);
      if (!ent && !ext) begin
        @(negedge clk);
        car_passed = 1'b1;
        @(negedge clk);
        car_passed = 1'b0;
        repeat (2) @(negedge clk);
      end else begin
        run_txn(ent, ext, 1'($urandom % 2), 1'($urandom % 2),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 4)));
      end
    end

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
